// File: rtl/nibble_cascade_comp.sv
// Nibble-serial magnitude comparator stage: folds NIBBLES per-nibble g/l/e results
// (MSB first) into one registered word verdict, returned over a valid/ready handshake.
module nibble_cascade_comp #(
  parameter int NIBBLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic g_in,
  input  logic l_in,
  input  logic e_in,
  output logic out_valid,
  input  logic out_ready,
  output logic G,
  output logic L,
  output logic E,
  output logic err
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_dec, w_dec_nx;
  logic          r_gacc, w_gacc_nx;
  logic          r_lacc, w_lacc_nx;
  logic          r_eacc, w_eacc_nx;
  logic          r_g, w_g_nx;
  logic          r_l, w_l_nx;
  logic          r_e, w_e_nx;
  logic          r_err, w_err_nx;
  logic          w_onehot;

  assign w_onehot = (g_in & ~l_in & ~e_in) | (~g_in & l_in & ~e_in) | (~g_in & ~l_in & e_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACC;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_gacc  <= 1'b0;
      r_lacc  <= 1'b0;
      r_eacc  <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dec   <= w_dec_nx;
      r_gacc  <= w_gacc_nx;
      r_lacc  <= w_lacc_nx;
      r_eacc  <= w_eacc_nx;
      r_g     <= w_g_nx;
      r_l     <= w_l_nx;
      r_e     <= w_e_nx;
      r_err   <= w_err_nx;
    end
  end

  // r_eacc accumulates encoding errors across the word; r_err is the presented copy.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dec_nx   = r_dec;
    w_gacc_nx  = r_gacc;
    w_lacc_nx  = r_lacc;
    w_eacc_nx  = r_eacc;
    w_g_nx     = r_g;
    w_l_nx     = r_l;
    w_e_nx     = r_e;
    w_err_nx   = r_err;
    case (r_state)
      ACC: begin
        if (in_valid) begin
          if (!r_dec && g_in) begin
            w_gacc_nx = 1'b1;
            w_lacc_nx = 1'b0;
            w_dec_nx  = 1'b1;
          end else if (!r_dec && l_in) begin
            w_gacc_nx = 1'b0;
            w_lacc_nx = 1'b1;
            w_dec_nx  = 1'b1;
          end
          w_eacc_nx = r_eacc | ~w_onehot;
          if (r_cnt == LAST) begin
            w_state_nx = HOLD;
            w_cnt_nx   = '0;
            w_g_nx     = w_gacc_nx;
            w_l_nx     = w_lacc_nx;
            w_e_nx     = ~w_dec_nx;
            w_err_nx   = w_eacc_nx;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nx = ACC;
          w_dec_nx   = 1'b0;
          w_gacc_nx  = 1'b0;
          w_lacc_nx  = 1'b0;
          w_eacc_nx  = 1'b0;
          w_g_nx     = 1'b0;
          w_l_nx     = 1'b0;
          w_e_nx     = 1'b0;
          w_err_nx   = 1'b0;
        end
      end
      default: w_state_nx = ACC;
    endcase
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign G         = r_g;
  assign L         = r_l;
  assign E         = r_e;
  assign err       = r_err;

endmodule

// File: tb/tb_nibble_cascade_comp.sv
// Directed bench for nibble_cascade_comp (NIBBLES=4): verdicts, stalls, gaps, err, reset.
module tb_nibble_cascade_comp;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, g_in, l_in, e_in;
  logic out_valid, out_ready, G, L, E, err;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nibble_cascade_comp #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .g_in(g_in), .l_in(l_in), .e_in(e_in), .out_valid(out_valid),
    .out_ready(out_ready), .G(G), .L(L), .E(E), .err(err)
  );

  // {out_valid, G, L, E, err}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {out_valid, G, L, E, err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    checks++;
    assert (in_ready === exp) else begin
      errors++;
      $error("FAIL %s: in_ready observed=%b expected=%b", tag, in_ready, exp);
    end
  endtask

  // One cycle with a nibble result presented; leaves in_valid low afterwards.
  task automatic beat(input logic g, input logic l, input logic e);
    in_valid = 1'b1; g_in = g; l_in = l; e_in = e;
    @(posedge clk); #1;
    in_valid = 1'b0; g_in = 1'b0; l_in = 1'b0; e_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; g_in = 1'b0; l_in = 1'b0; e_in = 1'b0; out_ready = 1'b1;
    idle(); idle();
    chk("reset_out", 5'b0_000_0);
    chk_rdy("reset_rdy", 1'b1);
    rst_n = 1'b1;
    idle();

    // 0x3A5C vs 0x3A4F: E,E,G,L
    beat(0,0,1); beat(0,0,1); beat(1,0,0);
    chk("w1_before_last", 5'b0_000_0);
    beat(0,1,0);
    chk("w1_verdict", 5'b1_100_0);
    idle();
    chk("w1_cleared", 5'b0_000_0);
    chk_rdy("w1_rdy", 1'b1);

    // 0x1234 vs 0x1234
    beat(0,0,1); beat(0,0,1); beat(0,0,1); beat(0,0,1);
    chk("w2_equal", 5'b1_001_0);
    idle();

    // 0x0FFF vs 0x1000: L,G,G,G
    beat(0,1,0); beat(1,0,0); beat(1,0,0); beat(1,0,0);
    chk("w3_first_wins", 5'b1_010_0);
    idle();

    // Stall in HOLD for 3 cycles with a pending beat offered
    out_ready = 1'b0;
    beat(0,0,1); beat(1,0,0); beat(0,0,1); beat(0,0,1);
    chk("w4_verdict", 5'b1_100_0);
    in_valid = 1'b1; l_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("w4_hold_stable", 5'b1_100_0);
      chk_rdy("w4_hold_rdy", 1'b0);
    end
    in_valid = 1'b0; l_in = 1'b0;
    out_ready = 1'b1;
    idle();
    chk("w4_handshake", 5'b0_000_0);
    chk_rdy("w4_rdy_back", 1'b1);
    beat(0,1,0); beat(0,0,1); beat(0,0,1); beat(0,0,1);
    chk("w5_after_stall", 5'b1_010_0);
    idle();

    // Gaps: in_valid 1,0,0,1,1,0,1 carrying E,E,G,L
    beat(0,0,1); idle(); idle(); beat(0,0,1); beat(1,0,0); idle();
    chk("w6_gap_pending", 5'b0_000_0);
    chk_rdy("w6_gap_rdy", 1'b1);
    beat(0,1,0);
    chk("w6_gap_verdict", 5'b1_100_0);
    idle();

    // Illegal encoding g=l=1, then clean word clears err
    beat(1,1,0); beat(0,0,1); beat(0,0,1); beat(0,0,1);
    chk("w7_err", 5'b1_100_1);
    idle();
    beat(0,0,1); beat(0,0,1); beat(0,0,1); beat(0,0,1);
    chk("w8_err_clear", 5'b1_001_0);
    idle();

    // All-zero beat: equal for verdict, flagged as error
    beat(0,0,0); beat(0,0,1); beat(0,0,1); beat(0,0,1);
    chk("w9_zero_beat", 5'b1_001_1);
    idle();

    // Reset after two beats discards the partial word
    beat(1,0,0); beat(0,1,0);
    rst_n = 1'b0;
    idle();
    chk("rst_mid_out", 5'b0_000_0);
    chk_rdy("rst_mid_rdy", 1'b1);
    rst_n = 1'b1;
    beat(0,1,0); beat(0,0,1); beat(0,0,1);
    chk("w10_partial", 5'b0_000_0);
    beat(0,0,1);
    chk("w10_fresh", 5'b1_010_0);
    idle();
    chk("w10_cleared", 5'b0_000_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
